opb_simulink2ppc_capture: RTL and testbench

Captures a 32-bit word from user fabric logic on a valid strobe and lets the PowerPC read it over OPB. This is the user-to-processor counterpart of the software-written control registers. It also provides a fresh-data flag, an overflow counter and a capture enable. It sits on the OPB bus next to the other software registers, and its address window is set by the base/high parameters.

---
 rtl/opb_simulink2ppc_capture.sv | 132 +++++++++++++
 tb/tb_opb_simulink2ppc_capture.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_simulink2ppc_capture.sv
// opb_simulink2ppc_capture: captures a user-fabric word on a valid strobe and
// exposes it to the PowerPC over OPB together with a fresh flag, a saturating
// overflow counter and a capture enable.
// Optional build macro: SNAP_HOLD_EN -- keep the first unread word instead of
// letting later captures overwrite it.
module opb_simulink2ppc_capture #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid
);

    localparam int unsigned AW = C_OPB_AWIDTH;
    localparam int unsigned DW = C_OPB_DWIDTH;

    localparam logic [1:0] IDX_DATA   = 2'd0;
    localparam logic [1:0] IDX_STATUS = 2'd1;
    localparam logic [1:0] IDX_CTRL   = 2'd2;

    logic [31:0]   r_data;
    logic          r_fresh;
    logic          r_enable;
    logic [7:0]    r_ovf;
    logic          r_ack;
    logic [0:DW-1] r_dbus;

    logic [AW:0]   w_lo_diff;
    logic [AW:0]   w_hi_diff;
    logic          w_hit;
    logic [1:0]    w_idx;
    logic          w_decode;
    logic          w_rd_clr;
    logic          w_wr_ctrl;
    logic          w_cap;
    logic          w_slot_busy;
    logic [31:0]   w_rd_word;
    logic          w_unused;

    // Ports that carry no information for this slave.
    assign w_unused = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:DW-3], |C_FAMILY};

    // Address decode, bus-cycle qualifiers and the read-data mux.
    always_comb begin
        w_lo_diff   = (AW+1)'(OPB_ABus) - (AW+1)'(C_BASEADDR);
        w_hi_diff   = (AW+1)'(C_HIGHADDR) - (AW+1)'(OPB_ABus);
        w_hit       = OPB_select & ~w_lo_diff[AW] & ~w_hi_diff[AW];
        w_idx       = OPB_ABus[AW-4:AW-3];
        w_decode    = w_hit & ~r_ack;
        // Side effects land on the edge that closes the ack cycle.
        w_rd_clr    = r_ack & w_hit & OPB_RNW & (w_idx == IDX_DATA);
        w_wr_ctrl   = r_ack & w_hit & ~OPB_RNW & (w_idx == IDX_CTRL) & OPB_BE[3];
        w_cap       = user_valid & r_enable;
        // A word being read out on this very edge frees the slot for the capture.
        w_slot_busy = r_fresh & ~w_rd_clr;
        w_rd_word   = '0;
        case (w_idx)
            IDX_DATA:   w_rd_word = r_data;
            IDX_STATUS: w_rd_word = {16'h0000, r_ovf, 6'b000000, r_enable, r_fresh};
            IDX_CTRL:   w_rd_word = {31'h0000_0000, r_enable};
            default:    w_rd_word = '0;
        endcase
    end

    // Bus response: one-cycle ack with data registered from the decode cycle.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_ack  <= 1'b0;
            r_dbus <= '0;
        end else begin
            r_ack  <= w_decode;
            r_dbus <= (w_decode & OPB_RNW) ? DW'(w_rd_word) : '0;
        end
    end

    // Capture path, fresh flag, overflow counter and CTRL register.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_data   <= '0;
            r_fresh  <= 1'b0;
            r_ovf    <= '0;
            r_enable <= 1'b1;
        end else begin
            if (w_cap) begin
                r_fresh <= 1'b1;
                if (w_slot_busy) begin
                    if (r_ovf != 8'hFF) begin
                        r_ovf <= 8'(r_ovf + 8'd1);
                    end
`ifdef SNAP_HOLD_EN
`else
                    r_data <= user_data_in;
`endif
                end else begin
                    r_data <= user_data_in;
                end
            end else if (w_rd_clr) begin
                r_fresh <= 1'b0;
            end
            // Clear follows the increment so a coincident clear wins.
            if (w_wr_ctrl) begin
                r_enable <= OPB_DBus[DW-1];
                if (OPB_DBus[DW-2]) begin
                    r_ovf <= '0;
                end
            end
        end
    end

    assign Sl_xferAck = r_ack;
    assign Sl_DBus    = r_dbus;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_simulink2ppc_capture.sv
// Bench for opb_simulink2ppc_capture: directed scenarios with literal
// expectations, then randomized bus/capture traffic checked every cycle
// against a behavioural model. Honors SNAP_HOLD_EN like the design.
module tb_opb_simulink2ppc_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seqaddr;
    logic [0:31] sl_dbus;
    logic        ack;
    logic        errack, retry, toutsup;
    logic [31:0] udata;
    logic        valid;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

`ifdef SNAP_HOLD_EN
    localparam logic [31:0] EXP_OVR_DATA = 32'h0000_0001;
`else
    localparam logic [31:0] EXP_OVR_DATA = 32'h0000_0003;
`endif

    opb_simulink2ppc_capture dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seqaddr),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (ack),
        .Sl_errAck    (errack),
        .Sl_retry     (retry),
        .Sl_toutSup   (toutsup),
        .user_data_in (udata),
        .user_valid   (valid)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model of the register file and bus response.
    logic [31:0] m_data;
    bit          m_fresh;
    bit          m_en;
    int          m_ovf;
    bit          m_ack;
    logic [31:0] m_dbus;

    function automatic logic [31:0] reg_value(input int idx);
        case (idx)
            0:       return m_data;
            1:       return {16'h0000, 8'(m_ovf), 6'b000000, m_en, m_fresh};
            2:       return {31'h0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] a;
        logic [31:0] wd;
        int          idx;
        bit          hit, decode, rdclr, wrc, cap;
        a      = abus;
        wd     = dbus;
        idx    = int'(a[3:2]);
        hit    = sel && (a[31:8] == 24'h0);
        decode = hit && !m_ack;
        rdclr  = m_ack && hit && rnw && (idx == 0);
        wrc    = m_ack && hit && !rnw && (idx == 2) && be[3];
        cap    = valid && m_en;
        if (rst) begin
            m_data = 0; m_fresh = 0; m_en = 1; m_ovf = 0; m_ack = 0; m_dbus = 0;
        end else begin
            m_dbus = (decode && rnw) ? reg_value(idx) : 32'h0;
            m_ack  = decode;
            if (cap) begin
                if (m_fresh && !rdclr) begin
                    m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
`ifndef SNAP_HOLD_EN
                    m_data = udata;
`endif
                end else begin
                    m_data = udata;
                end
                m_fresh = 1;
            end else if (rdclr) begin
                m_fresh = 0;
            end
            if (wrc) begin
                m_en = wd[0];
                if (wd[1]) m_ovf = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", 32'(ack), 32'(m_ack));
            check("dbus", sl_dbus, m_dbus);
            check("tied0", {29'h0, errack, retry, toutsup}, 32'h0);
        end
    end

    task automatic bus_idle();
        sel = 0; rnw = 1; abus = '0; be = '0; dbus = '0;
    endtask

    task automatic opb_xfer(input bit r, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] bev, output logic [31:0] rdata);
        bit got;
        @(posedge clk); #1;
        sel = 1; rnw = r; abus = addr; dbus = wdata; be = bev;
        got = 0; rdata = 32'hX;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack) begin got = 1; rdata = sl_dbus; end
        end
        if (!got) check("ack_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] v;
        opb_xfer(1'b1, addr, 32'h0, 4'hF, v);
        check(name, v, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] bev);
        logic [31:0] v;
        opb_xfer(1'b0, addr, data, bev, v);
    endtask

    task automatic pulse(input logic [31:0] d);
        @(posedge clk); #1;
        valid = 1; udata = d;
        @(posedge clk); #1;
        valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] w;
        rst = 1; valid = 0; udata = 0; seqaddr = 0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1;
        @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_dbus", sl_dbus, 32'h0);
        @(posedge clk); #1;
        rst = 0;

        // Reset values.
        rd(32'h4, 32'h0000_0002, "rst_status");
        rd(32'h0, 32'h0000_0000, "rst_data");

        // Single capture and read-clear.
        pulse(32'hDEAD_BEEF);
        rd(32'h4, 32'h0000_0003, "cap_status");
        rd(32'h0, 32'hDEAD_BEEF, "cap_data");
        rd(32'h4, 32'h0000_0002, "cap_status_cleared");

        // Overflow counting and clear.
        pulse(32'h1); pulse(32'h2); pulse(32'h3);
        rd(32'h4, 32'h0000_0203, "ovf_status");
        wr(32'h8, 32'h3, 4'hF);
        rd(32'h4, 32'h0000_0003, "ovf_cleared");
        rd(32'h0, EXP_OVR_DATA, "ovf_data");
        rd(32'h4, 32'h0000_0002, "ovf_read_clr");

        // Disable, capture ignored, byte-enable gating.
        wr(32'h8, 32'h0, 4'hF);
        rd(32'h4, 32'h0000_0000, "dis_status");
        pulse(32'h55);
        rd(32'h0, EXP_OVR_DATA, "dis_data");
        rd(32'h4, 32'h0000_0000, "dis_status2");
        wr(32'h8, 32'h1, 4'b1110);
        rd(32'h4, 32'h0000_0000, "be_gated");
        wr(32'h8, 32'h1, 4'hF);
        rd(32'h8, 32'h0000_0001, "ctrl_rd");
        rd(32'hC, 32'h0000_0000, "idx3_rd");

        // Capture on the edge that ends a DATA-read ack.
        pulse(32'h77);
        @(posedge clk); #1;
        sel = 1; rnw = 1; abus = 32'h0; be = 4'hF;
        @(posedge clk); #1;
        valid = 1; udata = 32'hAA;
        @(negedge clk);
        check("race_ack", 32'(ack), 32'h1);
        check("race_old", sl_dbus, 32'h77);
        @(posedge clk); #1;
        valid = 0;
        bus_idle();
        rd(32'h4, 32'h0000_0003, "race_status");
        rd(32'h0, 32'h0000_00AA, "race_data");

        // Overflow saturation.
        @(posedge clk); #1;
        valid = 1;
        repeat (300) begin
            udata = $urandom;
            @(posedge clk); #1;
        end
        valid = 0;
        rd(32'h4, 32'h0000_FF03, "sat_status");

        // Reset during an ack cycle.
        @(posedge clk); #1;
        sel = 1; rnw = 1; abus = 32'h4; be = 4'hF;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("midrst_ack_before", 32'(ack), 32'h1);
        @(negedge clk);
        check("midrst_ack", 32'(ack), 32'h0);
        @(posedge clk); #1;
        rst = 0;
        bus_idle();
        rd(32'h4, 32'h0000_0002, "midrst_status");
        rd(32'h0, 32'h0000_0000, "midrst_data");

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            valid = ($urandom % 4 == 0);
            udata = $urandom;
            rst   = ($urandom % 400 == 0);
            if (!sel || ($urandom % 3 == 0)) begin
                sel = $urandom % 2;
                rnw = $urandom % 2;
                v   = {28'h0, 2'($urandom), 2'b00};
                if ($urandom % 8 == 0) v = v | 32'h100;
                abus = v;
                w = $urandom;
                if ($urandom % 4 != 0) w[0] = 1'b1;
                if ($urandom % 3 != 0) w[1] = 1'b0;
                dbus = w;
                be = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
            end
        end
        @(posedge clk); #1;
        rst = 0; valid = 0;
        bus_idle();
        repeat (4) @(posedge clk);
        #1;
        chk_on = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
